jtag_master: RTL
================

# jtag_master

Clocked JTAG initiator that drives TCK/TMS/TDI and samples TDO of an external or on-board TAP, such as the Murax debug port. It shifts host-supplied TMS/TDI vectors of 1–32 bits per command and returns the captured TDO vector. The command side is fed by a CPU peripheral or a UART bridge on `io_mainClk`. The block is the host end of the JTAG link that the Murax SoC exposes as a target.

## Interface
- `CLK_DIV`, default 4: TCK half-period in `io_mainClk` cycles. Legal range is 3..255.
- `io_mainClk`  in  1  system clock; all logic is on its rising edge.
- `io_asyncResetn`  in  1  asynchronous active-low reset, deasserted synchronously upstream.
- `io_cmd_valid`  in  1  command offered.
- `io_cmd_ready`  out  1  command accepted when both valid and ready are 1.
- `io_cmd_len`  in  5  bit count minus 1; 0 means 1 bit and 31 means 32 bits.
- `io_cmd_tms`  in  32  TMS vector, LSB first.
- `io_cmd_tdi`  in  32  TDI vector, LSB first.
- `io_rsp_valid`  out  1  captured TDO available.
- `io_rsp_ready`  in  1  response consumed when both valid and ready are 1.
- `io_rsp_tdo`  out  32  captured TDO, LSB first; bits at positions above len are 0.
- `io_busy`  out  1  high in every state except IDLE.
- `io_jtag_tck`  out  1  TCK.
- `io_jtag_tms`  out  1  TMS.
- `io_jtag_tdi`  out  1  TDI.
- `io_jtag_tdo`  in  1  TDO, asynchronous to `io_mainClk`.

## Operation
- **Reset values:** tck=0, tms=1, tdi=0, cmd_ready=0 while reset is asserted, rsp_valid=0, rsp_tdo=0, busy=0, state IDLE.
- **States:** IDLE, LOW, HIGH, RESP.
- **IDLE**
  - cmd_ready=1 and tck=0.
  - On accept: latch len, tms and tdi; set bit index i=0; clear the capture register.
  - Drive tms and tdi from bit 0, load the divider with CLK_DIV-1, and go to LOW.
- **LOW**
  - tck=0; the divider decrements each cycle.
  - When the divider reaches 0: set tck=1, write the synchronized TDO into capture bit i, reload the divider, and go to HIGH.
- **HIGH**
  - tck=1; the divider decrements each cycle.
  - When the divider reaches 0: set tck=0.
  - If i==len, go to RESP.
  - Otherwise increment i, drive tms and tdi from bit i, reload the divider, and go to LOW.
- **RESP**
  - rsp_valid=1 and rsp_tdo holds the capture register.
  - cmd_ready=0 and tck stays 0.
  - tms and tdi hold their last-bit values.
  - On rsp handshake: rsp_valid=0 and go to IDLE.
- **Between commands:** tms and tdi hold their last driven values. This lets a TAP stay parked in Run-Test/Idle or a Pause state.
- **TDO synchronizer:** TDO passes through a 2-flop synchronizer. The target updates TDO on the TCK falling edge, CLK_DIV cycles before the next sample, so CLK_DIV>=3 guarantees the sampled value is settled.
- **Back-to-back commands:** there is no TCK pulse between commands. A new command can be accepted no earlier than 1 cycle after the response handshake.
- **Reset mid-command:** everything returns to reset values immediately. The partial shift is discarded and no response is produced. The TAP state is then undefined, and the host must issue 5 TMS=1 clocks.

## Timing
- **Command accept:** happens at edge 0.
- **Per bit k** (k = 0..len):
  - tms and tdi change after edge 2·CLK_DIV·k.
  - tck rises after edge 2·CLK_DIV·k + CLK_DIV, and TDO is sampled at that same edge.
  - tck falls after edge 2·CLK_DIV·(k+1).
- **Response:** rsp_valid rises after edge 2·CLK_DIV·(len+1), the same edge as the last tck fall.
- **Duty cycle:** TCK is exactly 50 %, with period 2·CLK_DIV.
- **Setup and hold at the target:** TMS and TDI are stable CLK_DIV cycles before and CLK_DIV cycles after each TCK rise.
- **Response stall:** rsp_valid, rsp_tdo, tck, tms and tdi are all stable for as long as rsp_ready=0.

## Structure
- **Shared package `jtag_master_pkg`:**
  - `state_t` enum (IDLE, LOW, HIGH, RESP).
  - `JTAG_MAX_BITS = 32`.
  - `JTAG_LEN_W = 5`.
  - Reset-value constants for tck, tms and tdi.
- **Sub-module:** `sync_2ff`, a generic 2-flop synchronizer with asynchronous active-low reset. It is instantiated once, for TDO.
- **Top level:** the divider, bit index, shift/capture registers and FSM all live in `jtag_master`.

## Test plan
- **Reset:** assert reset for 5 cycles, including while a command is offered → tck=0, tms=1, tdi=0, rsp_valid=0, busy=0. After release, cmd_ready=1 on the first cycle.
- **Single bit:** CLK_DIV=4, len=0, tms=0x1, tdi=0x1, TDO tied 1 → exactly one TCK pulse, with rise after edge 4 and fall after edge 8. rsp_valid rises after edge 8 with rsp_tdo=0x00000001.
- **TAP reset and IDCODE:** drive a bench TAP model with IDCODE 0x10001FFF using three commands:
  - len=4, tms=0x1F (TAP reset);
  - len=3, tms=0x2 (to Shift-DR);
  - len=31, tms=0x80000000, tdi=0.

  Required: the third response is rsp_tdo=0x10001FFF, and the model ends in Exit1-DR.
- **Response backpressure:** hold rsp_ready=0 for 20 cycles with a second command valid → rsp_valid and rsp_tdo stable, tck=0 and cmd_ready=0 throughout. The second command is accepted 1 cycle after the response handshake.
- **Reset mid-shift:** assert reset after edge 37 of a len=31 command → outputs return to reset values in the same cycle, with no response. After release, a len=0 command completes normally.
- **Loopback timing:** connect tdi to tdo through a model that updates on the TCK falling edge, len=7, tdi=0xA5 → rsp_tdo=0x4A, i.e. 0xA5 shifted by 1 bit with a 0 shifted in. A checker confirms a 50 % TCK duty cycle and that TMS/TDI never change within CLK_DIV cycles of a TCK rise.

Source files
------------

// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the JTAG initiator.
//   state_t     : FSM states (IDLE, LOW, HIGH, RESP)
//   jtag_cmd_t  : latched command payload (len, tms, tdi)
//   *_RST       : reset / park values of the JTAG pins
package jtag_master_pkg;

  localparam int unsigned JTAG_MAX_BITS = 32;
  localparam int unsigned JTAG_LEN_W    = 5;
  // Divider counter width; large enough for CLK_DIV up to 255.
  localparam int unsigned DIV_W         = 8;

  localparam logic TCK_RST = 1'b0;
  localparam logic TMS_RST = 1'b1;
  localparam logic TDI_RST = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [JTAG_LEN_W-1:0]    len;
    logic [JTAG_MAX_BITS-1:0] tms;
    logic [JTAG_MAX_BITS-1:0] tdi;
  } jtag_cmd_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into both stages
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync_2ff #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Clocked JTAG initiator: shifts 1..32 TMS/TDI bits per command out on
// TCK/TMS/TDI and returns the TDO bits captured on each TCK rise.
//   io_mainClk / io_asyncResetn : system clock, async active-low reset
//   io_cmd_*   : command (valid/ready, len = bits-1, tms, tdi, LSB first)
//   io_rsp_*   : response (valid/ready, captured tdo, LSB first)
//   io_busy    : high whenever the FSM is not in IDLE
//   io_jtag_*  : JTAG pins; tdo is asynchronous and synchronized here
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                     io_mainClk,
  input  logic                     io_asyncResetn,
  input  logic                     io_cmd_valid,
  output logic                     io_cmd_ready,
  input  logic [JTAG_LEN_W-1:0]    io_cmd_len,
  input  logic [JTAG_MAX_BITS-1:0] io_cmd_tms,
  input  logic [JTAG_MAX_BITS-1:0] io_cmd_tdi,
  output logic                     io_rsp_valid,
  input  logic                     io_rsp_ready,
  output logic [JTAG_MAX_BITS-1:0] io_rsp_tdo,
  output logic                     io_busy,
  output logic                     io_jtag_tck,
  output logic                     io_jtag_tms,
  output logic                     io_jtag_tdi,
  input  logic                     io_jtag_tdo
);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [JTAG_LEN_W-1:0]    idx_q, idx_d;
  logic [JTAG_LEN_W-1:0]    idx_inc;
  jtag_cmd_t                cmd_q, cmd_d;
  logic [JTAG_MAX_BITS-1:0] cap_q, cap_d;
  logic                     tck_q, tck_d;
  logic                     tms_q, tms_d;
  logic                     tdi_q, tdi_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     busy_q, busy_d;
  logic                     tdo_s;
  logic                     accept;
  logic                     rsp_hs;
  logic                     div_zero;
  logic                     last_bit;

  // TDO crosses from the target's TCK domain; settles CLK_DIV cycles before use.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_tdo_sync (
    .clk   (io_mainClk),
    .rst_n (io_asyncResetn),
    .d     (io_jtag_tdo),
    .q     (tdo_s)
  );

  assign accept   = (state_q == IDLE) && io_cmd_valid && cmd_ready_q;
  assign rsp_hs   = (state_q == RESP) && rsp_valid_q && io_rsp_ready;
  assign div_zero = (div_q == '0);
  assign last_bit = (idx_q == cmd_q.len);
  assign idx_inc  = idx_q + JTAG_LEN_W'(1);

  // State register.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)   state_d = LOW;
      LOW:  if (div_zero) state_d = HIGH;
      HIGH: if (div_zero) state_d = last_bit ? RESP : LOW;
      RESP: if (rsp_hs)   state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pins hold unless a bit boundary moves them.
  always_comb begin
    div_d       = div_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    cap_d       = cap_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;

    case (state_q)
      IDLE: begin
        tck_d = 1'b0;
        if (accept) begin
          cmd_d.len = io_cmd_len;
          cmd_d.tms = io_cmd_tms;
          cmd_d.tdi = io_cmd_tdi;
          idx_d     = '0;
          cap_d     = '0;
          tms_d     = io_cmd_tms[0];
          tdi_d     = io_cmd_tdi[0];
          div_d     = DIV_RELOAD;
        end
      end
      LOW: begin
        if (div_zero) begin
          tck_d        = 1'b1;
          cap_d[idx_q] = tdo_s;
          div_d        = DIV_RELOAD;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      HIGH: begin
        if (div_zero) begin
          tck_d = 1'b0;
          if (!last_bit) begin
            idx_d = idx_inc;
            tms_d = cmd_q.tms[idx_inc];
            tdi_d = cmd_q.tdi[idx_inc];
            div_d = DIV_RELOAD;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      RESP: begin
        tck_d = 1'b0;
      end
      default: begin
        tck_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      div_q       <= '0;
      idx_q       <= '0;
      cmd_q       <= '0;
      cap_q       <= '0;
      tck_q       <= TCK_RST;
      tms_q       <= TMS_RST;
      tdi_q       <= TDI_RST;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      cap_q       <= cap_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign io_cmd_ready = cmd_ready_q;
  assign io_rsp_valid = rsp_valid_q;
  assign io_rsp_tdo   = cap_q;
  assign io_busy      = busy_q;
  assign io_jtag_tck  = tck_q;
  assign io_jtag_tms  = tms_q;
  assign io_jtag_tdi  = tdi_q;

endmodule
